// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one FIFO write port; define FIFO_WR_ARB_BURST_EN for multi-beat grants
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ-1:0]       req_last_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic                  fifo_full_i,
  output logic                  fifo_wen_o,
  output logic [WIDTH-1:0]      fifo_data_o,
  output logic [NREQ-1:0]       grant_o,
  output logic                  busy_o
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [IW-1:0] gnt_idx, last_idx, pick, cand;
  logic [NREQ-1:0] onehot;
  logic acc, burst_end;
  // first valid requester after the round-robin pointer, lowest offset wins
  always_comb begin
    pick = '0;
    cand = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IW'((int'(last_idx) + i) % NREQ);
      if (req_valid_i[cand]) pick = cand;
    end
  end
  assign onehot      = NREQ'(1) << gnt_idx;
  assign busy_o      = (state == GRANT);
  assign acc         = busy_o && req_valid_i[gnt_idx] && !fifo_full_i;
  assign fifo_wen_o  = acc;
  assign req_ready_o = acc ? onehot : '0;
  assign grant_o     = busy_o ? onehot : '0;
  assign fifo_data_o = busy_o ? req_data_i[int'(gnt_idx)*WIDTH +: WIDTH] : '0;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] beat_cnt;
  assign burst_end = acc && (req_last_i[gnt_idx] || beat_cnt == CW'(MAX_BURST - 1));
  // beats accepted in the current grant; frozen while the FIFO is full
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) beat_cnt <= '0;
    else if (state == IDLE) beat_cnt <= '0;
    else if (acc) beat_cnt <= beat_cnt + 1'b1;
`else
  logic unused_last;
  assign unused_last = ^req_last_i;
  assign burst_end   = acc;
`endif
  // arbitrate in IDLE, hold the grant until the burst ends
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      last_idx <= IW'(NREQ - 1);
    end else if (state == IDLE) begin
      if (|req_valid_i) begin
        state    <= GRANT;
        gnt_idx  <= pick;
        last_idx <= pick;
      end
    end else if (burst_end) state <= IDLE;
endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter that shares one `fifo_scd` write port between `NREQ` requesters in the same clock domain. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a burst, and drives the FIFO's write enable and data. Back-pressure comes from the FIFO `full_o` flag. It sits directly in front of the shared FIFO instance, with the read side untouched.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `WIDTH`, 32: data word width; must match the FIFO `WIDTH`.
- `MAX_BURST`, 4: maximum beats per grant, ≥1; used only with `FIFO_WR_ARB_BURST_EN`.

- `clk_i`, in, 1: clock, rising edge.
- `arst_ni`, in, 1: asynchronous reset, active low.
- `req_valid_i`, in, NREQ: per-requester beat valid.
- `req_last_i`, in, NREQ: per-requester last-beat-of-burst marker, qualified by valid.
- `req_data_i`, in, NREQ*WIDTH: requester i data in bits [i*WIDTH +: WIDTH].
- `req_ready_o`, out, NREQ: per-requester beat accepted this cycle.
- `fifo_full_i`, in, 1: FIFO `full_o`.
- `fifo_wen_o`, out, 1: FIFO `wen_i`.
- `fifo_data_o`, out, WIDTH: FIFO `data_i`.
- `grant_o`, out, NREQ: one-hot current owner, all-zero when idle.
- `busy_o`, out, 1: state is GRANT.

## Operation
- FSM with two states, IDLE and GRANT. Registered state: `gnt_idx`, round-robin pointer `last_idx`, beat counter `beat_cnt` of $clog2(MAX_BURST+1) bits.
- **IDLE**
  - If any `req_valid_i` is high, pick the first valid index searching upward from `last_idx+1`, wrapping modulo NREQ.
  - Register the pick into `gnt_idx` and `last_idx`, clear `beat_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - A beat is accepted when `req_valid_i[gnt_idx] && !fifo_full_i`.
  - On acceptance:
    - `fifo_wen_o` = 1.
    - `fifo_data_o` = the granted requester's data.
    - `req_ready_o[gnt_idx]` = 1.
    - `beat_cnt` increments.
  - Burst ends on an accepted beat with `req_last_i[gnt_idx]`, or with `beat_cnt == MAX_BURST-1`. At burst end the next state is IDLE.
  - A granted requester dropping valid mid-burst does not release the grant; the arbiter holds and waits. Requesters must complete bursts.
- `fifo_wen_o`, `req_ready_o` and `fifo_data_o` are combinational from registered state plus `req_valid_i`/`fifo_full_i`. `fifo_data_o` shows the granted requester's data whenever in GRANT, and is all-zero in IDLE.
- Requesters must hold valid/data/last stable until ready.
- Non-granted requesters always see ready = 0.
- Reset values:
  - State = IDLE.
  - `last_idx` = NREQ-1, so requester 0 has first priority.
  - `gnt_idx` = 0 and `beat_cnt` = 0.
  - Outputs: `fifo_wen_o` = 0, `req_ready_o` = 0, `grant_o` = 0, `busy_o` = 0, `fifo_data_o` = 0.
- Reset asserted mid-burst returns to IDLE immediately. Any partial burst already in the FIFO stays there; the arbiter does not retract it.

## Timing
- Arbitration latency: 1 cycle. Valid seen in IDLE leads to GRANT on the next edge; the first beat can be accepted in that GRANT cycle.
- Throughput inside a burst: 1 beat/cycle while not full.
- Each burst costs one idle arbitration cycle, so the peak rate is MAX_BURST/(MAX_BURST+1).
- `fifo_full_i` high freezes the burst. No beats are accepted, the counter is held, and the grant is held.
- Simultaneous requests are resolved strictly by round-robin order after `last_idx`. The pointer updates only on grant.

## Configuration
- `FIFO_WR_ARB_BURST_EN` defined:
  - Burst behaviour as above.
  - `req_last_i` and `MAX_BURST` are honoured.
- Not defined:
  - Every grant is a single beat.
  - `req_last_i` and `MAX_BURST` are ignored.
  - The first accepted beat ends the grant and the FSM returns to IDLE, so the max rate is 1 beat per 2 cycles.
  - `beat_cnt` is not instantiated.

## Test plan
- **Reset:** hold `arst_ni` low with all valids high. All outputs stay 0. Release reset; requester 0 is granted on the first edge and its beat is written on the next cycle.
- **Round-robin:** NREQ=4 with valids 4'b1111 held and single-beat bursts. Grants go 0,1,2,3,0; each requester gets exactly one `fifo_wen_o` per rotation.
- **Burst cap:** BURST_EN, MAX_BURST=4, requester 2 streaming 6 beats with no last. 4 consecutive writes, then IDLE, then re-grant to requester 2 if it is the only requester. All 6 words reach the FIFO in order.
- **Back-pressure:** `fifo_full_i` high for 3 cycles mid-burst. No wen and no ready during those cycles; the grant is unchanged; the burst resumes the cycle after full drops with no beat lost or duplicated.
- **Early last:** requester 1 sends 2 beats with last on beat 2 while requester 3 is waiting. Requester 1 gets 2 writes, then IDLE for 1 cycle, then requester 3 is granted.
- **Reset mid-burst:** pulse `arst_ni` low after beat 2 of 4. Outputs go to 0 asynchronously; after release, arbitration restarts from requester 0.
